// File: rtl/fifo_playout_ctrl.sv
// fifo_playout_ctrl: read-side scheduler for the DDS SSB UART sample FIFO.
// Waits for the FIFO to reach START_LEVEL, then pops one word every rate_div+1
// clocks and presents it as a registered sample. An empty FIFO on a due pop
// raises a one-cycle underrun pulse and re-primes through PREFILL.
// Optional feature: define PLAYOUT_UNDERRUN_CNT_EN to get a saturating
// underrun counter; otherwise underrun_count is tied to zero.
module fifo_playout_ctrl #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned DIV_WIDTH   = 16,
    parameter int unsigned START_LEVEL = 512,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [DIV_WIDTH-1:0]  rate_div,
    input  logic [ADDR_WIDTH:0]   fifo_count,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] sample_out,
    output logic                  sample_valid,
    output logic                  underrun,
    output logic [CNT_WIDTH-1:0]  underrun_count,
    output logic [1:0]            state_out
);

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StPrefill  = 2'd1,
        StPlay     = 2'd2,
        StUnderrun = 2'd3
    } state_e;

    localparam logic [ADDR_WIDTH:0] StartLevel = (ADDR_WIDTH + 1)'(START_LEVEL);

    state_e               state_q;
    logic [DIV_WIDTH-1:0] cnt_q;
    logic [DIV_WIDTH-1:0] div_q;
    logic                 rd_pending_q;
    logic                 tick;
    logic                 underrun_set;

    // End of a pacing period while playing out.
    assign tick         = (state_q == StPlay) && (cnt_q == div_q);
    assign underrun_set = tick & enable & fifo_empty;
    assign fifo_rd_en   = tick & enable & ~fifo_empty & ~rst;
    assign state_out    = state_q;

    // Playout state machine, pace counter and underrun pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            div_q    <= '0;
            underrun <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (!enable) begin
                state_q <= StIdle;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    StIdle: begin
                        state_q <= StPrefill;
                        cnt_q   <= '0;
                    end
                    StPrefill: begin
                        if (fifo_count >= StartLevel) begin
                            state_q <= StPlay;
                            cnt_q   <= '0;
                            div_q   <= rate_div;
                        end
                    end
                    StPlay: begin
                        if (tick) begin
                            // New divider only takes effect from the next period.
                            cnt_q <= '0;
                            div_q <= rate_div;
                            if (fifo_empty) begin
                                state_q  <= StUnderrun;
                                underrun <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + DIV_WIDTH'(1);
                        end
                    end
                    StUnderrun: begin
                        state_q <= StPrefill;
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    // Read-data path: capture FIFO data one cycle after the pop, then pulse valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pending_q <= 1'b0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
        end else begin
            rd_pending_q <= fifo_rd_en;
            sample_valid <= rd_pending_q;
            if (rd_pending_q) begin
                sample_out <= fifo_dout;
            end
        end
    end

`ifdef PLAYOUT_UNDERRUN_CNT_EN
    logic [CNT_WIDTH-1:0] ucnt_q;

    // Saturating underrun total, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ucnt_q <= '0;
        end else if (underrun_set && (ucnt_q != {CNT_WIDTH{1'b1}})) begin
            ucnt_q <= ucnt_q + CNT_WIDTH'(1);
        end
    end

    assign underrun_count = ucnt_q;
`else
    assign underrun_count = '0;
`endif

endmodule
